wb_dma_mc: RTL and testbench

//  Parametrised multi-channel memory-to-memory DMA engine for the user project area.

---
 rtl/wb_dma_mc.sv | 248 ++++++++++++++++++++++++
 tb/tb_wb_dma_mc.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_dma_mc.sv
// Multi-channel memory-to-memory DMA: Wishbone slave register file per channel,
// one shared Wishbone master copying 32-bit words, channels served round-robin.
module wb_dma_mc #(
    parameter int          NUM_CH    = 2,
    parameter int          LEN_W     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    output logic              wbm_we_o,
    output logic [3:0]        wbm_sel_o,
    output logic [31:0]       wbm_adr_o,
    output logic [31:0]       wbm_dat_o,
    input  logic [31:0]       wbm_dat_i,
    input  logic              wbm_ack_i,
    output logic [NUM_CH-1:0] irq
);
    localparam int          CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [31:0] SPAN = 32'(16 * NUM_CH);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_NEXT} state_t;

    // programmed registers and working copies used by the engine
    logic [31:0]       src_q  [NUM_CH];
    logic [31:0]       src_d  [NUM_CH];
    logic [31:0]       dst_q  [NUM_CH];
    logic [31:0]       dst_d  [NUM_CH];
    logic [LEN_W-1:0]  len_q  [NUM_CH];
    logic [LEN_W-1:0]  len_d  [NUM_CH];
    logic [31:0]       wsrc_q [NUM_CH];
    logic [31:0]       wsrc_d [NUM_CH];
    logic [31:0]       wdst_q [NUM_CH];
    logic [31:0]       wdst_d [NUM_CH];
    logic [LEN_W-1:0]  wrem_q [NUM_CH];
    logic [LEN_W-1:0]  wrem_d [NUM_CH];
    logic [NUM_CH-1:0] busy_q, busy_d, done_q, done_d, irq_en_q, irq_en_d;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   cur_q, cur_d, rr_q, rr_d, pick, fin_ch;
    logic              pick_vld, finish;
    logic [31:0]       data_q, data_d;

    logic              wbs_ack_q, wbs_ack_d;
    logic [31:0]       wbs_dat_q, wbs_dat_d;
    logic              wbm_req_q, wbm_req_d, wbm_we_q, wbm_we_d;
    logic [31:0]       wbm_adr_q, wbm_adr_d, wbm_dat_q, wbm_dat_d;

    logic              acc, mapped, m_ack;
    logic [31:0]       off, rd_val;
    logic [CH_W-1:0]   acc_ch;
    logic [1:0]        acc_reg;
    logic [CH_W:0]     idx;
    logic              unused_sig;

    assign acc        = wbs_cyc_i & wbs_stb_i & ~wbs_ack_q;
    assign off        = wbs_adr_i - BASE_ADDR;
    assign mapped     = (wbs_adr_i >= BASE_ADDR) && (off < SPAN);
    assign acc_ch     = off[CH_W+3:4];
    assign acc_reg    = off[3:2];
    assign m_ack      = wbm_req_q & wbm_ack_i;
    assign unused_sig = ^wbs_sel_i;

    assign wbs_ack_o  = wbs_ack_q;
    assign wbs_dat_o  = wbs_dat_q;
    assign wbm_cyc_o  = wbm_req_q;
    assign wbm_stb_o  = wbm_req_q;
    assign wbm_we_o   = wbm_we_q;
    assign wbm_sel_o  = 4'hF;
    assign wbm_adr_o  = wbm_adr_q;
    assign wbm_dat_o  = wbm_dat_q;
    assign irq        = done_q & irq_en_q;

    always_comb begin
        rd_val = '0;
        if (mapped) begin
            case (acc_reg)
                2'd0:    rd_val = src_q[acc_ch];
                2'd1:    rd_val = dst_q[acc_ch];
                2'd2:    rd_val = 32'(len_q[acc_ch]);
                default: rd_val = {28'd0, busy_q[acc_ch], done_q[acc_ch], irq_en_q[acc_ch], 1'b0};
            endcase
        end
    end

    // Walk offsets downwards so the nearest busy channel at/after rr_q wins.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        idx      = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = {1'b0, rr_q} + (CH_W+1)'(k);
            if (idx >= (CH_W+1)'(NUM_CH))
                idx = idx - (CH_W+1)'(NUM_CH);
            if (busy_q[idx[CH_W-1:0]]) begin
                pick     = idx[CH_W-1:0];
                pick_vld = 1'b1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        rr_d    = rr_q;
        finish  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    cur_d = pick;
                    if (wrem_q[pick] == '0)
                        finish = 1'b1;
                    else
                        state_d = S_RD;
                end
            end
            S_RD:    if (m_ack) state_d = S_WR;
            S_WR:    if (m_ack) state_d = S_NEXT;
            default: begin
                if (wrem_q[cur_q] == LEN_W'(1))
                    finish = 1'b1;
                else
                    state_d = S_RD;
            end
        endcase
        fin_ch = (state_q == S_IDLE) ? pick : cur_q;
        if (finish) begin
            state_d = S_IDLE;
            rr_d    = (fin_ch == CH_W'(NUM_CH - 1)) ? '0 : fin_ch + CH_W'(1);
        end
    end

    // Register file and engine datapath
    always_comb begin
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        wsrc_d    = wsrc_q;
        wdst_d    = wdst_q;
        wrem_d    = wrem_q;
        busy_d    = busy_q;
        done_d    = done_q;
        irq_en_d  = irq_en_q;
        data_d    = data_q;
        wbs_ack_d = acc;
        wbs_dat_d = (acc && !wbs_we_i) ? rd_val : 32'd0;

        if (acc && wbs_we_i && mapped) begin
            case (acc_reg)
                2'd0: if (!busy_q[acc_ch]) src_d[acc_ch] = {wbs_dat_i[31:2], 2'b00};
                2'd1: if (!busy_q[acc_ch]) dst_d[acc_ch] = {wbs_dat_i[31:2], 2'b00};
                2'd2: if (!busy_q[acc_ch]) len_d[acc_ch] = wbs_dat_i[LEN_W-1:0];
                default: begin
                    irq_en_d[acc_ch] = wbs_dat_i[1];
                    if (wbs_dat_i[2])
                        done_d[acc_ch] = 1'b0;
                    if (wbs_dat_i[0] && !busy_q[acc_ch]) begin
                        busy_d[acc_ch] = 1'b1;
                        wsrc_d[acc_ch] = src_q[acc_ch];
                        wdst_d[acc_ch] = dst_q[acc_ch];
                        wrem_d[acc_ch] = len_q[acc_ch];
                    end
                end
            endcase
        end

        if (state_q == S_RD && m_ack)
            data_d = wbm_dat_i;
        if (state_q == S_NEXT) begin
            wsrc_d[cur_q] = wsrc_q[cur_q] + 32'd4;
            wdst_d[cur_q] = wdst_q[cur_q] + 32'd4;
            wrem_d[cur_q] = wrem_q[cur_q] - LEN_W'(1);
        end
        // applied after the W1C so a same-cycle hardware set wins
        if (finish) begin
            busy_d[fin_ch] = 1'b0;
            done_d[fin_ch] = 1'b1;
        end
    end

    // Output logic: master request drops in the cycle after every ack
    always_comb begin
        wbm_req_d = 1'b0;
        wbm_we_d  = 1'b0;
        wbm_adr_d = '0;
        wbm_dat_d = '0;
        if ((state_q == S_RD || state_q == S_WR) && !m_ack) begin
            wbm_req_d = 1'b1;
            wbm_we_d  = (state_q == S_WR);
            wbm_adr_d = (state_q == S_WR) ? wdst_q[cur_q] : wsrc_q[cur_q];
            wbm_dat_d = (state_q == S_WR) ? data_q : 32'd0;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= S_IDLE;
            cur_q     <= '0;
            rr_q      <= '0;
            data_q    <= '0;
            src_q     <= '{default: '0};
            dst_q     <= '{default: '0};
            len_q     <= '{default: '0};
            wsrc_q    <= '{default: '0};
            wdst_q    <= '{default: '0};
            wrem_q    <= '{default: '0};
            busy_q    <= '0;
            done_q    <= '0;
            irq_en_q  <= '0;
            wbs_ack_q <= 1'b0;
            wbs_dat_q <= '0;
            wbm_req_q <= 1'b0;
            wbm_we_q  <= 1'b0;
            wbm_adr_q <= '0;
            wbm_dat_q <= '0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            rr_q      <= rr_d;
            data_q    <= data_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            wsrc_q    <= wsrc_d;
            wdst_q    <= wdst_d;
            wrem_q    <= wrem_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            irq_en_q  <= irq_en_d;
            wbs_ack_q <= wbs_ack_d;
            wbs_dat_q <= wbs_dat_d;
            wbm_req_q <= wbm_req_d;
            wbm_we_q  <= wbm_we_d;
            wbm_adr_q <= wbm_adr_d;
            wbm_dat_q <= wbm_dat_d;
        end
    end
endmodule

// File: tb/tb_wb_dma_mc.sv
// Directed bench for wb_dma_mc: drives the slave port, models a memory slave
// on the master port (read data = address ^ 0x5A5A_0000) and logs each master ack.
module tb_wb_dma_mc;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] PAT  = 32'h5A5A_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_cyc = 1'b0, s_stb = 1'b0, s_we = 1'b0;
    logic [31:0] s_adr = '0, s_dat = '0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [31:0] m_dat;
    logic        m_ack;
    logic [1:0]  irq;

    int vectors = 0;
    int errors  = 0;
    int ack_delay = 0;
    int ack_cnt;
    logic        log_we  [$];
    logic [31:0] log_adr [$];
    logic [31:0] log_dat [$];

    always #5 clk = ~clk;

    wb_dma_mc #(.NUM_CH(2), .LEN_W(16), .BASE_ADDR(BASE)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(s_cyc), .wbs_stb_i(s_stb), .wbs_we_i(s_we), .wbs_sel_i(4'hF),
        .wbs_adr_i(s_adr), .wbs_dat_i(s_dat), .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(m_dat), .wbm_ack_i(m_ack),
        .irq(irq)
    );

    // memory slave with programmable ack delay
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ack   <= 1'b0;
            m_dat   <= '0;
            ack_cnt <= 0;
        end else begin
            m_ack <= 1'b0;
            if (wbm_cyc_o && wbm_stb_o && !m_ack) begin
                if (ack_cnt >= ack_delay) begin
                    m_ack   <= 1'b1;
                    ack_cnt <= 0;
                    m_dat   <= wbm_adr_o ^ PAT;
                    log_we.push_back(wbm_we_o);
                    log_adr.push_back(wbm_adr_o);
                    log_dat.push_back(wbm_we_o ? wbm_dat_o : 32'h0);
                end else begin
                    ack_cnt <= ack_cnt + 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wb_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                             output logic [31:0] r);
        int n;
        @(negedge clk);
        s_cyc = 1'b1; s_stb = 1'b1; s_we = w; s_adr = a; s_dat = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!wbs_ack_o && n < 20);
        check("slave_ack", {31'd0, wbs_ack_o}, 32'd1);
        r = wbs_dat_o;
        s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0;
        $display("%s adr=%h dat=%h", w ? "wr" : "rd", a, w ? d : r);
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r;
        wb_access(1'b1, a, d, r);
    endtask

    task automatic wb_read_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] r;
        wb_access(1'b0, a, 32'd0, r);
        check(tag, r, exp);
    endtask

    task automatic wait_not_busy(input logic [31:0] a);
        logic [31:0] r;
        int n = 0;
        do begin
            wb_access(1'b0, a, 32'd0, r);
            n++;
        end while (r[3] && n < 300);
        check("busy_clear", {31'd0, r[3]}, 32'd0);
    endtask

    task automatic wait_irq(input string tag, input logic [1:0] exp, input int budget);
        int n = 0;
        while (irq !== exp && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, {30'd0, irq}, {30'd0, exp});
    endtask

    // one RD/WR pair starting at log entry k
    task automatic check_pair(input int k, input logic [31:0] src, input logic [31:0] dst);
        if (k + 1 < log_adr.size()) begin
            check("rd_we",  {31'd0, log_we[k]},   32'd0);
            check("rd_adr", log_adr[k],           src);
            check("wr_we",  {31'd0, log_we[k+1]}, 32'd1);
            check("wr_adr", log_adr[k+1],         dst);
            check("wr_dat", log_dat[k+1],         src ^ PAT);
        end else begin
            check("pair_present", log_adr.size(), k + 2);
        end
    endtask

    initial begin
        int base;
        logic seen_cyc;
        logic found;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_ack", {31'd0, wbs_ack_o}, 32'd0);
        check("rst_cyc", {31'd0, wbm_cyc_o}, 32'd0);
        check("rst_irq", {30'd0, irq}, 32'd0);
        rst = 1'b0;
        wb_read_chk("rst_ctrl0", BASE + 32'h0C, 32'd0);
        wb_read_chk("rst_src1",  BASE + 32'h10, 32'd0);

        // 1: four-word copy on ch0, start latency
        wb_write(BASE + 32'h00, 32'h100);
        wb_write(BASE + 32'h04, 32'h200);
        wb_write(BASE + 32'h08, 32'd4);
        base = log_adr.size();
        wb_write(BASE + 32'h0C, 32'h1);
        @(negedge clk);
        check("lat_stb_lo", {31'd0, wbm_stb_o}, 32'd0);
        @(negedge clk);
        check("lat_stb_hi", {31'd0, wbm_stb_o}, 32'd1);
        check("lat_adr", wbm_adr_o, 32'h100);
        wait_not_busy(BASE + 32'h0C);
        check("t1_count", log_adr.size() - base, 32'd8);
        check_pair(base + 0, 32'h100, 32'h200);
        check_pair(base + 2, 32'h104, 32'h204);
        check_pair(base + 4, 32'h108, 32'h208);
        check_pair(base + 6, 32'h10C, 32'h20C);
        wb_read_chk("t1_ctrl", BASE + 32'h0C, 32'h4);
        wb_read_chk("t1_src_kept", BASE + 32'h00, 32'h100);
        check("t1_irq", {30'd0, irq}, 32'd0);

        // 2: two channels queued, irq per channel, W1C
        wb_write(BASE + 32'h0C, 32'h4);
        wb_write(BASE + 32'h00, 32'h400);
        wb_write(BASE + 32'h04, 32'h500);
        wb_write(BASE + 32'h08, 32'd2);
        wb_write(BASE + 32'h10, 32'h600);
        wb_write(BASE + 32'h14, 32'h700);
        wb_write(BASE + 32'h18, 32'd2);
        base = log_adr.size();
        wb_write(BASE + 32'h0C, 32'h3);
        wb_write(BASE + 32'h1C, 32'h3);
        wait_irq("t2_irq_ch0", 2'b01, 100);
        wait_irq("t2_irq_both", 2'b11, 100);
        check("t2_count", log_adr.size() - base, 32'd8);
        check_pair(base + 0, 32'h400, 32'h500);
        check_pair(base + 2, 32'h404, 32'h504);
        check_pair(base + 4, 32'h600, 32'h700);
        check_pair(base + 6, 32'h604, 32'h704);
        wb_write(BASE + 32'h0C, 32'h6);
        check("t2_irq_w1c", {30'd0, irq}, 32'h2);

        // 3: zero-length transfer completes without bus cycles
        wb_write(BASE + 32'h08, 32'd0);
        base = log_adr.size();
        wb_write(BASE + 32'h0C, 32'h3);
        seen_cyc = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen_cyc = seen_cyc | wbm_cyc_o;
        end
        check("t3_no_cyc", {31'd0, seen_cyc}, 32'd0);
        check("t3_irq", {30'd0, irq}, 32'h3);
        wb_read_chk("t3_ctrl", BASE + 32'h0C, 32'h6);
        check("t3_count", log_adr.size() - base, 32'd0);

        // 4: source address wraps through zero
        wb_write(BASE + 32'h00, 32'hFFFF_FFFC);
        wb_write(BASE + 32'h04, 32'h800);
        wb_write(BASE + 32'h08, 32'd2);
        base = log_adr.size();
        wb_write(BASE + 32'h0C, 32'h7);
        wait_not_busy(BASE + 32'h0C);
        check("t4_count", log_adr.size() - base, 32'd4);
        check_pair(base + 0, 32'hFFFF_FFFC, 32'h800);
        check_pair(base + 2, 32'h0000_0000, 32'h804);
        wb_read_chk("t4_ctrl", BASE + 32'h0C, 32'h6);

        // 5: slow slave, writes to a busy channel are ignored
        ack_delay = 10;
        wb_write(BASE + 32'h00, 32'h900);
        wb_write(BASE + 32'h04, 32'hA00);
        wb_write(BASE + 32'h08, 32'd3);
        base = log_adr.size();
        wb_write(BASE + 32'h0C, 32'h1);
        wb_write(BASE + 32'h00, 32'hDEAD);
        wb_read_chk("t5_src_busy", BASE + 32'h00, 32'h900);
        wb_read_chk("t5_ctrl_busy", BASE + 32'h0C, 32'hC);
        wb_write(BASE + 32'h0C, 32'h1);
        wait_not_busy(BASE + 32'h0C);
        repeat (30) @(negedge clk);
        check("t5_count", log_adr.size() - base, 32'd6);
        check_pair(base + 4, 32'h908, 32'hA08);
        wb_read_chk("t5_ctrl", BASE + 32'h0C, 32'h4);

        // 6: reset during a write cycle
        ack_delay = 3;
        wb_write(BASE + 32'h00, 32'hB00);
        wb_write(BASE + 32'h04, 32'hC00);
        wb_write(BASE + 32'h08, 32'd4);
        wb_write(BASE + 32'h0C, 32'h1);
        found = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            @(negedge clk);
            found = wbm_stb_o & wbm_we_o;
        end
        check("t6_wr_seen", {31'd0, found}, 32'd1);
        rst = 1'b1;
        #1;
        check("t6_cyc_drop", {31'd0, wbm_cyc_o}, 32'd0);
        check("t6_stb_drop", {31'd0, wbm_stb_o}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen_cyc = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen_cyc = seen_cyc | wbm_cyc_o;
        end
        check("t6_idle_after", {31'd0, seen_cyc}, 32'd0);
        check("t6_irq", {30'd0, irq}, 32'd0);
        wb_read_chk("t6_ctrl0", BASE + 32'h0C, 32'd0);
        wb_read_chk("t6_ctrl1", BASE + 32'h1C, 32'd0);
        wb_read_chk("t6_src0",  BASE + 32'h00, 32'd0);
        wb_write(BASE + 32'h20, 32'h1234);
        wb_read_chk("t6_unmapped_hi", BASE + 32'h20, 32'd0);
        wb_read_chk("t6_unmapped_lo", 32'h2FFF_FFF0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
